// File: rtl/vcmd_pkg.sv
// Shared definitions for the video command burst decoder:
// opcodes, FSM state encoding and the address-byte-count helper.
package vcmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_FCOL = 3'd3,
      ST_FRUN = 3'd4
   } state_t;

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_SETADDR = 2'b10;
   localparam logic [1:0] OP_FILL    = 2'b11;

   // Number of SETADDR payload bytes needed to cover an address of addr_w bits.
   function automatic int unsigned addr_bytes(input int unsigned addr_w);
      return (addr_w + 32'd7) / 32'd8;
   endfunction

endpackage

// File: rtl/vcmd_pixstep.sv
// Channel index / pixel address stepper shared by WRITE and FILL.
// Each advance moves to the next channel; the last channel bumps the address (wrapping).
module vcmd_pixstep #(
   parameter int ADDR_W   = 18,
   parameter int CHANNELS = 3,
   parameter int IDX_W    = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              clr,
   input  logic              advance,
   output logic [IDX_W-1:0]  idx,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

   logic [IDX_W-1:0]  idx_r;
   logic [ADDR_W-1:0] addr_r;

   assign idx  = idx_r;
   assign addr = addr_r;
   assign last = (idx_r == IDX_LAST);

   // Load wins over clear (abort drops a partial pixel), clear wins over advance.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         idx_r  <= '0;
         addr_r <= '0;
      end else if (load) begin
         idx_r  <= '0;
         addr_r <= load_addr;
      end else if (clr) begin
         idx_r  <= '0;
      end else if (advance) begin
         if (last) begin
            idx_r  <= '0;
            addr_r <= addr_r + ADDR_W'(1);
         end else begin
            idx_r  <= idx_r + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/vcmd_burst.sv
// SPI command-stream decoder: SETADDR / WRITE / FILL into a pixel memory,
// emitting one registered channel-byte write per DataRdy strobe.
module vcmd_burst
   import vcmd_pkg::*;
#(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 3,
   parameter int CNT_W    = 6,
   localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              Clk,
   input  logic              NRst,
   input  logic              CmdRecv,
   input  logic [DATA_W-1:0] CmdIn,
   input  logic              Abort,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] DataOut,
   output logic [IDX_W-1:0]  DataIndex,
   output logic              DataRdy,
   output logic              Busy,
   output logic              Err
);

   localparam int         ABYTES     = int'(addr_bytes(ADDR_W));
   localparam logic [2:0] ABYTE_LAST = 3'(ABYTES - 1);
   localparam logic [2:0] COL_LAST   = 3'(CHANNELS - 1);

   state_t              state_r, state_s;
   logic [2:0]          bcnt_r;
   logic [CNT_W-1:0]    pix_r;
   logic [ADDR_W-1:0]   acc_r, acc_next_s;
   logic [DATA_W-1:0]   colour_r [0:(1 << IDX_W) - 1];

   logic                wr_s, fill_s, step_load_s, step_clr_s, err_set_s, last_wr_s;
   logic [DATA_W-1:0]   wr_data_s;
   logic [IDX_W-1:0]    step_idx;
   logic [ADDR_W-1:0]   step_addr;
   logic                step_last;

   // MSB-first shift; bits beyond ADDR_W fall off the top.
   assign acc_next_s = ADDR_W'({acc_r, CmdIn});

   vcmd_pixstep #(
      .ADDR_W  (ADDR_W),
      .CHANNELS(CHANNELS),
      .IDX_W   (IDX_W)
   ) u_step (
      .clk      (Clk),
      .nrst     (NRst),
      .load     (step_load_s),
      .load_addr(acc_next_s),
      .clr      (step_clr_s),
      .advance  (wr_s),
      .idx      (step_idx),
      .addr     (step_addr),
      .last     (step_last)
   );

   // State register.
   always_ff @(posedge Clk) begin
      if (!NRst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and per-cycle write/control decode.
   always_comb begin
      state_s     = state_r;
      wr_s        = 1'b0;
      fill_s      = 1'b0;
      wr_data_s   = CmdIn;
      step_load_s = 1'b0;
      step_clr_s  = 1'b0;
      err_set_s   = 1'b0;
      last_wr_s   = step_last && (pix_r == '0);
      if (Abort) begin
         state_s    = ST_IDLE;
         step_clr_s = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (CmdRecv) begin
                  case (CmdIn[7:6])
                     OP_SETADDR: state_s = ST_ADDR;
                     OP_WRITE:   state_s = ST_DATA;
                     OP_FILL:    state_s = ST_FCOL;
                     default:    state_s = ST_IDLE;
                  endcase
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (CmdRecv && (bcnt_r == ABYTE_LAST)) begin
                  step_load_s = 1'b1;
                  state_s     = ST_IDLE;
               end else begin
                  state_s = ST_ADDR;
               end
            end
            ST_DATA: begin
               if (CmdRecv) begin
                  wr_s    = 1'b1;
                  state_s = last_wr_s ? ST_IDLE : ST_DATA;
               end else begin
                  state_s = ST_DATA;
               end
            end
            ST_FCOL: begin
               // The first fill write goes out on the same edge that latches the last colour byte.
               if (CmdRecv && (bcnt_r == COL_LAST)) begin
                  wr_s      = 1'b1;
                  fill_s    = 1'b1;
                  wr_data_s = (CHANNELS == 1) ? CmdIn : colour_r[0];
                  state_s   = last_wr_s ? ST_IDLE : ST_FRUN;
               end else begin
                  state_s = ST_FCOL;
               end
            end
            ST_FRUN: begin
               wr_s      = 1'b1;
               fill_s    = 1'b1;
               wr_data_s = colour_r[step_idx];
               err_set_s = CmdRecv;
               state_s   = last_wr_s ? ST_IDLE : ST_FRUN;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Byte counter, pixel counter, address accumulator and colour latch.
   always_ff @(posedge Clk) begin
      if (!NRst) begin
         bcnt_r <= 3'd0;
         pix_r  <= '0;
         acc_r  <= '0;
         for (int i = 0; i < (1 << IDX_W); i++) begin
            colour_r[i] <= '0;
         end
      end else begin
         if (!Abort && CmdRecv && (state_r == ST_IDLE)) begin
            bcnt_r <= 3'd0;
            acc_r  <= '0;
            pix_r  <= CmdIn[CNT_W-1:0];
         end else if (!Abort && CmdRecv && ((state_r == ST_ADDR) || (state_r == ST_FCOL))) begin
            bcnt_r <= bcnt_r + 3'd1;
            acc_r  <= acc_next_s;
            if (state_r == ST_FCOL) begin
               colour_r[bcnt_r[IDX_W-1:0]] <= CmdIn;
            end
         end
         if (wr_s && step_last) begin
            pix_r <= pix_r - CNT_W'(1);
         end
      end
   end

   // Registered write port and status flags; address/data/index hold between writes.
   always_ff @(posedge Clk) begin
      if (!NRst) begin
         MemAddr   <= '0;
         DataOut   <= '0;
         DataIndex <= '0;
         DataRdy   <= 1'b0;
         Busy      <= 1'b0;
         Err       <= 1'b0;
      end else begin
         DataRdy <= wr_s;
         Busy    <= wr_s && fill_s;
         Err     <= Err | err_set_s;
         if (wr_s) begin
            MemAddr   <= step_addr;
            DataOut   <= wr_data_s;
            DataIndex <= step_idx;
         end
      end
   end

endmodule

// File: tb/tb_vcmd_burst.sv
// Self-checking bench for vcmd_burst: table vectors, directed corner sequences
// and random command streams checked against a command-level write model.
module tb_vcmd_burst;

   localparam int ADDR_SPAN = 1 << 18;

   logic        Clk = 1'b0;
   logic        NRst = 1'b0;
   logic        CmdRecv = 1'b0;
   logic [7:0]  CmdIn = 8'h00;
   logic        Abort = 1'b0;
   logic [17:0] MemAddr;
   logic [7:0]  DataOut;
   logic [1:0]  DataIndex;
   logic        DataRdy;
   logic        Busy;
   logic        Err;

   vcmd_burst dut (
      .Clk      (Clk),
      .NRst     (NRst),
      .CmdRecv  (CmdRecv),
      .CmdIn    (CmdIn),
      .Abort    (Abort),
      .MemAddr  (MemAddr),
      .DataOut  (DataOut),
      .DataIndex(DataIndex),
      .DataRdy  (DataRdy),
      .Busy     (Busy),
      .Err      (Err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [17:0] addr;
      logic [1:0]  idx;
      logic [7:0]  data;
      logic        busy;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [7:0]  a2, a1, a0;
      logic [7:0]  d0, d1, d2;
      logic [17:0] exp_addr;
      logic [17:0] exp_next;
   } vec_t;

   wr_t         act_q[$];
   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          busy_cnt = 0;
   int unsigned m_addr = 0;

   // Collect every write the DUT emits, sampled away from the rising edge.
   always @(negedge Clk) begin
      cyc++;
      if (DataRdy) act_q.push_back('{MemAddr, DataIndex, DataOut, Busy, cyc});
      if (Busy) busy_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      CmdIn   = b;
      CmdRecv = 1'b1;
      tick();
      CmdRecv = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      NRst = 1'b0;
      tick();
      NRst = 1'b1;
      m_addr = 0;
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic push_exp(input logic [17:0] a, input int idx, input logic [7:0] d, input logic b);
      wr_t e;
      e.addr = a;
      e.idx  = 2'(idx);
      e.data = d;
      e.busy = b;
      e.cyc  = 0;
      exp_q.push_back(e);
   endtask

   // Reference: a WRITE/FILL of n pixels covers n consecutive addresses, 3 channels each.
   task automatic model_burst(input logic [7:0] cmd, input logic [7:0] payload[$], input bit fill);
      int npix;
      npix = int'(cmd[5:0]) + 1;
      for (int i = 0; i < npix * 3; i++) begin
         push_exp(18'((m_addr + i / 3) % ADDR_SPAN), i % 3, fill ? payload[i % 3] : payload[i], fill);
      end
      m_addr = (m_addr + npix) % ADDR_SPAN;
   endtask

   task automatic compare_all(input string name);
      wr_t e, a;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (act_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s missing write: got none required addr=%0h idx=%0d data=%0h", name, e.addr, e.idx, e.data);
         end else begin
            a = act_q.pop_front();
            if (a.addr !== e.addr || a.idx !== e.idx || a.data !== e.data || a.busy !== e.busy) begin
               n_fail++;
               $display("FAIL %s write: got addr=%0h idx=%0d data=%0h busy=%0b required addr=%0h idx=%0d data=%0h busy=%0b",
                        name, a.addr, a.idx, a.data, a.busy, e.addr, e.idx, e.data, e.busy);
            end
         end
      end
      check({name, "_extra_writes"}, act_q.size(), 0);
      act_q.delete();
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (Busy && k < 400) begin
         tick();
         k++;
      end
      check({name, "_idle"}, {31'd0, Busy}, 0);
   endtask

   vec_t        vt[4];
   logic [7:0]  pl[$];
   logic [7:0]  cmd, b0, b1, b2;
   int          b_start, first_cyc;

   initial begin
      vt[0] = '{8'h00, 8'h01, 8'h23, 8'h11, 8'h22, 8'h33, 18'h00123, 18'h00124};
      vt[1] = '{8'h03, 8'hFF, 8'hFF, 8'hA0, 8'hA1, 8'hA2, 18'h3FFFF, 18'h00000};
      vt[2] = '{8'hFF, 8'hFF, 8'hFE, 8'h5A, 8'h5B, 8'h5C, 18'h3FFFE, 18'h3FFFF};
      vt[3] = '{8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03, 18'h23456, 18'h23457};

      tick();
      do_reset();
      check("rst_MemAddr", {14'd0, MemAddr}, 0);
      check("rst_DataOut", {24'd0, DataOut}, 0);
      check("rst_DataIndex", {30'd0, DataIndex}, 0);
      check("rst_DataRdy", {31'd0, DataRdy}, 0);
      check("rst_Busy", {31'd0, Busy}, 0);
      check("rst_Err", {31'd0, Err}, 0);

      // Table: SETADDR then two single-pixel WRITEs, checking load, truncation and wrap.
      for (int v = 0; v < 4; v++) begin
         send(8'h80); send(vt[v].a2); send(vt[v].a1); send(vt[v].a0);
         send(8'h40); send(vt[v].d0); send(vt[v].d1); send(vt[v].d2);
         push_exp(vt[v].exp_addr, 0, vt[v].d0, 1'b0);
         push_exp(vt[v].exp_addr, 1, vt[v].d1, 1'b0);
         push_exp(vt[v].exp_addr, 2, vt[v].d2, 1'b0);
         send(8'h40); send(~vt[v].d0); send(~vt[v].d1); send(~vt[v].d2);
         push_exp(vt[v].exp_next, 0, ~vt[v].d0, 1'b0);
         push_exp(vt[v].exp_next, 1, ~vt[v].d1, 1'b0);
         push_exp(vt[v].exp_next, 2, ~vt[v].d2, 1'b0);
         tick();
         compare_all($sformatf("vec%0d", v));
      end
      check("vec_Err", {31'd0, Err}, 0);

      // SETADDR 0x123, WRITE two pixels: each write one cycle after its strobe.
      do_reset();
      send(8'h80); send(8'h00); send(8'h01); send(8'h23);
      send(8'h41);
      for (int i = 0; i < 6; i++) begin
         send(8'h10 + 8'(i));
         check("write_latency_DataRdy", {31'd0, DataRdy}, 1);
         push_exp((i < 3) ? 18'h00123 : 18'h00124, i % 3, 8'h10 + 8'(i), 1'b0);
      end
      tick();
      check("write_DataRdy_drop", {31'd0, DataRdy}, 0);
      check("write_hold_MemAddr", {14'd0, MemAddr}, 32'h124);
      compare_all("write2pix");

      // FILL 4 pixels after SETADDR 0: 12 back-to-back writes, Busy for exactly 12 cycles.
      send(8'h80); send(8'h00); send(8'h00); send(8'h00);
      b_start = busy_cnt;
      send(8'hC3); send(8'hC0); send(8'hC0); send(8'hC0);
      check("fill_start_DataRdy", {31'd0, DataRdy}, 1);
      check("fill_start_Busy", {31'd0, Busy}, 1);
      wait_idle("fill4");
      tick();
      check("fill_busy_cycles", busy_cnt - b_start, 12);
      check("fill_write_count", act_q.size(), 12);
      if (act_q.size() == 12) check("fill_consecutive", act_q[11].cyc - act_q[0].cyc, 11);
      m_addr = 0;
      pl = '{8'hC0, 8'hC0, 8'hC0};
      model_burst(8'hC3, pl, 1'b1);
      compare_all("fill4");

      // Byte strobed during FRUN is dropped and flags Err; the fill is unaffected.
      send(8'h80); send(8'h00); send(8'h00); send(8'h05);
      m_addr = 5;
      send(8'hC1); send(8'h11); send(8'h22); send(8'h33);
      tick();
      send(8'h40);
      wait_idle("fill_err");
      tick();
      pl = '{8'h11, 8'h22, 8'h33};
      model_burst(8'hC1, pl, 1'b1);
      compare_all("fill_err");
      check("frun_Err_set", {31'd0, Err}, 1);
      repeat (3) tick();
      check("frun_Err_sticky", {31'd0, Err}, 1);

      // Abort mid-pixel (with a simultaneous strobe) then a fresh WRITE at the same address.
      do_reset();
      send(8'h80); send(8'h00); send(8'h01); send(8'h00);
      send(8'h40); send(8'hAA); send(8'hBB);
      CmdIn = 8'hCC; CmdRecv = 1'b1; Abort = 1'b1;
      tick();
      CmdRecv = 1'b0; Abort = 1'b0;
      check("abort_no_DataRdy", {31'd0, DataRdy}, 0);
      send(8'h40); send(8'h01); send(8'h02); send(8'h03);
      tick();
      push_exp(18'h00100, 0, 8'hAA, 1'b0);
      push_exp(18'h00100, 1, 8'hBB, 1'b0);
      push_exp(18'h00100, 0, 8'h01, 1'b0);
      push_exp(18'h00100, 1, 8'h02, 1'b0);
      push_exp(18'h00100, 2, 8'h03, 1'b0);
      compare_all("abort_rewrite");
      check("abort_Err", {31'd0, Err}, 0);

      // Reset during FRUN clears everything and stops the fill.
      do_reset();
      send(8'hFF); send(8'h01); send(8'h02); send(8'h03);
      repeat (10) tick();
      NRst = 1'b0;
      tick();
      check("frun_rst_DataRdy", {31'd0, DataRdy}, 0);
      check("frun_rst_Busy", {31'd0, Busy}, 0);
      check("frun_rst_MemAddr", {14'd0, MemAddr}, 0);
      check("frun_rst_DataOut", {24'd0, DataOut}, 0);
      check("frun_rst_DataIndex", {30'd0, DataIndex}, 0);
      NRst = 1'b1;
      act_q.delete();
      repeat (20) tick();
      check("frun_rst_no_writes", act_q.size(), 0);
      m_addr = 0;
      send(8'h40); send(8'h7A); send(8'h7B); send(8'h7C);
      tick();
      pl = '{8'h7A, 8'h7B, 8'h7C};
      model_burst(8'h40, pl, 1'b0);
      compare_all("after_rst_write");

      // Random command streams against the model.
      for (int n = 0; n < 40; n++) begin
         cmd = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 15))};
         pl.delete();
         repeat ($urandom_range(0, 2)) tick();
         send(cmd);
         case (cmd[7:6])
            2'b10: begin
               b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
               send(b0); send(b1); send(b2);
               m_addr = ((int'(b0) << 16) | (int'(b1) << 8) | int'(b2)) % ADDR_SPAN;
            end
            2'b01: begin
               for (int i = 0; i < (int'(cmd[5:0]) + 1) * 3; i++) begin
                  repeat ($urandom_range(0, 2)) tick();
                  pl.push_back(8'($urandom));
                  send(pl[i]);
               end
               model_burst(cmd, pl, 1'b0);
            end
            2'b11: begin
               for (int i = 0; i < 3; i++) begin
                  repeat ($urandom_range(0, 2)) tick();
                  pl.push_back(8'($urandom));
                  send(pl[i]);
               end
               model_burst(cmd, pl, 1'b1);
               wait_idle("rand_fill");
            end
            default: begin
            end
         endcase
         tick();
         compare_all($sformatf("rand%0d", n));
      end
      check("rand_Err", {31'd0, Err}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vcmd_burst.md
VCMD_BURST -- requirements
Module: vcmd_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, byte width; fixed at 8.
REQ-003 SHALL have parameter CHANNELS, default 3, bytes per pixel; range 1..4.
REQ-004 SHALL have parameter CNT_W, default 6, width of the pixel-count field in the command byte; range 1..6.
REQ-005 SHALL have port Clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port NRst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port CmdRecv  input  1  one-cycle strobe: CmdIn holds a new received SPI byte.
REQ-008 SHALL have port CmdIn  input  8  received byte.
REQ-009 SHALL have port Abort  input  1  abandon the current command (driven from chip-select release).
REQ-010 SHALL have port MemAddr  output  ADDR_W  pixel address of the current write.
REQ-011 SHALL have port DataOut  output  8  channel byte to write.
REQ-012 SHALL have port DataIndex  output  clog2(CHANNELS) (min 1)  channel of DataOut.
REQ-013 SHALL have port DataRdy  output  1  one-cycle write strobe qualifying MemAddr/DataOut/DataIndex.
REQ-014 SHALL have port Busy  output  1  high while the FILL generator runs.
REQ-015 SHALL have port Err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL decode command byte fields: opcode = bits[7:6]; N = bits[CNT_W-1:0]; pixel count = N+1.
REQ-017 SHALL treat opcode 00 as NOP; stay IDLE.
REQ-018 SHALL treat opcode 10 (SETADDR) as: the next ceil(ADDR_W/8) bytes, MSB first, load the address register; excess upper bits are discarded.
REQ-019 SHALL treat opcode 01 (WRITE) as: the next (N+1)*CHANNELS bytes are each emitted with DataIndex cycling 0..CHANNELS-1.
REQ-020 SHALL increment the address register by 1, modulo 2^ADDR_W, after each byte with DataIndex = CHANNELS-1.
REQ-021 SHALL treat opcode 11 (FILL) as: latch the next CHANNELS bytes as a colour, then autonomously emit (N+1)*CHANNELS writes, one per cycle, with the same index and address stepping as WRITE.
REQ-022 SHALL assert DataRdy, for a WRITE byte, exactly one cycle after its CmdRecv, with outputs registered.
REQ-023 SHALL start FILL emission the cycle after the last colour byte's CmdRecv.
REQ-024 SHALL hold Busy high from the first FILL write cycle through the last, and low otherwise.
REQ-025 SHALL implement states IDLE, ADDR, DATA, FCOL, FRUN.
REQ-026 SHALL make these state transitions:
- IDLE->ADDR|DATA|FCOL on the command byte.
- ADDR->IDLE after the last address byte.
- DATA->IDLE after the last data byte.
- FCOL->FRUN after the last colour byte.
- FRUN->IDLE after the last write.
REQ-027 SHALL drop any CmdRecv arriving in FRUN, with no write for it, and set Err.
REQ-028 SHALL return to IDLE on Abort in any state the next cycle; it drops the partial pixel, keeps the address register (already-completed pixels advanced it), does not assert DataRdy in that cycle, and does not set Err.
REQ-029 SHALL give Abort priority over a simultaneous CmdRecv.
REQ-030 SHALL keep MemAddr, DataOut and DataIndex at their last values when DataRdy is low.
REQ-031 SHALL wrap the address at 2^ADDR_W-1 -> 0 without an error.
REQ-032 SHALL keep Err set until reset.

Reset
REQ-033 SHALL, when NRst is low at a rising Clk edge, set state IDLE, address register 0, MemAddr 0, DataOut 0, DataIndex 0, DataRdy 0, Busy 0, Err 0, and clear the byte/pixel counters and colour registers.
REQ-034 SHALL abandon a reset asserted mid-command or mid-FILL completely, with no write emitted in the reset cycle.

Structure
REQ-035 SHALL place the opcode constants, the state encoding and the address-byte-count function in a shared package vcmd_pkg.
REQ-036 SHALL include one sub-module, vcmd_pixstep: a channel index and pixel address stepper (advance, load, wrap) used by both WRITE and FILL.

Verification
REQ-037 SHALL verify: SETADDR 0x80,0x00,0x01,0x23, then WRITE 0x41 with 6 bytes -> six DataRdy; addresses 0x00123 x3, then 0x00124 x3; DataIndex 0,1,2,0,1,2.
REQ-038 SHALL verify: FILL 0xC3 with colour C0,C0,C0 after SETADDR 0 -> 12 consecutive DataRdy; addresses 0..3; Busy high exactly 12 cycles.
REQ-039 SHALL verify: SETADDR 0x3FFFF, then WRITE 0x40 with 3 bytes -> writes at 0x3FFFF; next WRITE lands at 0x00000.
REQ-040 SHALL verify: a byte strobed during FRUN -> no extra DataRdy; Err = 1; FILL completes unchanged.
REQ-041 SHALL verify: Abort after 2 of 3 bytes of a WRITE, then a new WRITE -> the new WRITE restarts at DataIndex 0 at the unchanged address; Err = 0.
REQ-042 SHALL verify: NRst low during FRUN -> the next cycle shows all outputs 0 and state IDLE; no further writes.
